// File: rtl/scan_rb_pkg.sv
// Shared types and helpers for the scan-chain readback controller.
package scan_rb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  // Number of output words needed to carry len bits in w-bit words.
  function automatic int unsigned word_count(input int unsigned len, input int unsigned w);
    return (len + w - 1) / w;
  endfunction

endpackage

// File: rtl/scan_word_packer.sv
// Packs serially sampled chain bits into WORD_W-bit words and presents
// them on a valid/ready holding register; flags a stall when a full
// accumulator cannot move into the holding register.
module scan_word_packer
  import scan_rb_pkg::*;
#(
  parameter int unsigned WORD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              sample_i,
  input  logic              bit_i,
  input  logic              last_i,
  input  logic              dout_ready_i,
  output logic [WORD_W-1:0] dout_o,
  output logic              dout_valid_o,
  output logic              stall_o,
  output logic              pending_o
);

  localparam int unsigned IDX_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic              pend;
  logic              hold_free;
  logic              move;

  // A word is ready to move when full, or when the final bit has been taken
  // and a partial word remains.
  assign pend      = (idx_q == IDX_W'(WORD_W)) || (last_q && (idx_q != '0));
  assign hold_free = !valid_q || dout_ready_i;
  assign move      = pend && hold_free;
  assign stall_o   = pend && !hold_free;
  assign pending_o = pend;

  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;

  // Next-state for accumulator, bit index and holding register.
  always_comb begin
    acc_d   = acc_q;
    idx_d   = idx_q;
    last_d  = last_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    if (valid_q && dout_ready_i) begin
      valid_d = 1'b0;
    end
    // Move and sample may share an edge: the accumulator restarts empty
    // (zero upper bits) and the new bit lands at index 0.
    if (move) begin
      dout_d  = acc_q;
      valid_d = 1'b1;
      acc_d   = '0;
      idx_d   = '0;
    end
    if (sample_i) begin
      for (int unsigned i = 0; i < WORD_W; i++) begin
        if (IDX_W'(i) == idx_d) begin
          acc_d[i] = bit_i;
        end
      end
      idx_d = idx_d + IDX_W'(1);
      if (last_i) begin
        last_d = 1'b1;
      end
    end
    if (clear_i) begin
      acc_d  = '0;
      idx_d  = '0;
      last_d = 1'b0;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/scan_readback_ctrl.sv
// Scan-chain readback controller: one functional capture edge, then
// CHAIN_LEN shift edges, streaming the chain contents out as words.
module scan_readback_ctrl
  import scan_rb_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 17,
  parameter int unsigned WORD_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              recirc,
  input  logic              scan_so,
  output logic              scan_en,
  output logic              scan_ce,
  output logic              scan_si,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic             recirc_q, recirc_d;
  logic             clear;
  logic             sample;
  logic             last_bit;
  logic             stall;
  logic             word_pending;
  logic             ce_c;
  logic             en_c;
  logic             si_c;
  logic             done_c;

  assign last_bit = (bitcnt_q == CNT_W'(CHAIN_LEN - 1));

  // FSM next state, bit counter and chain control.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    recirc_d = recirc_q;
    clear    = 1'b0;
    sample   = 1'b0;
    ce_c     = 1'b0;
    en_c     = 1'b0;
    si_c     = 1'b0;
    done_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ce_c = 1'b1;
        if (start) begin
          recirc_d = recirc;
          bitcnt_d = '0;
          clear    = 1'b1;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        ce_c    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        en_c   = 1'b1;
        si_c   = recirc_q & scan_so;
        ce_c   = !stall;
        sample = !stall;
        if (sample) begin
          bitcnt_d = bitcnt_q + CNT_W'(1);
          if (last_bit) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!word_pending && dout_valid && dout_ready) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, bit counter and latched recirc mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      recirc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      recirc_q <= recirc_d;
    end
  end

  // IDLE drives CE high combinationally, so reset must force it low directly.
  assign scan_ce = ce_c & rst;
  assign scan_en = en_c;
  assign scan_si = si_c;
  assign busy    = (state_q != IDLE);
  assign done    = done_c;

  scan_word_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk          (clk),
    .rst_n        (rst),
    .clear_i      (clear),
    .sample_i     (sample),
    .bit_i        (scan_so),
    .last_i       (last_bit),
    .dout_ready_i (dout_ready),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .stall_o      (stall),
    .pending_o    (word_pending)
  );

endmodule

// File: tb/tb_scan_readback_ctrl.sv
// Scoreboarded bench: chain models feed the DUTs, expected words are
// queued at request time and popped by a negedge monitor on each transfer.
module tb_scan_readback_ctrl;
  import scan_rb_pkg::*;

  localparam int unsigned L = 17;
  localparam int unsigned W = 4;
  localparam int unsigned NW = word_count(L, W);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (defaults)
  logic         start = 1'b0, recirc = 1'b0, dout_ready = 1'b0;
  logic         scan_so, scan_en, scan_ce, scan_si, dout_valid, busy, done;
  logic [W-1:0] dout;
  logic [L-1:0] chain_q = '0, func_v = '0, exp_chain = '0;

  scan_readback_ctrl #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .recirc(recirc), .scan_so(scan_so),
    .scan_en(scan_en), .scan_ce(scan_ce), .scan_si(scan_si), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done));

  // chain_q[0] is the last flop (drives scan_so); shift moves toward index 0.
  assign scan_so = chain_q[0];
  always @(posedge clk)
    if (scan_ce) chain_q <= scan_en ? {scan_si, chain_q[L-1:1]} : func_v;

  // Second DUT: single full-width word
  logic       start8 = 1'b0, ready8 = 1'b1;
  logic       so8, en8, ce8, si8, valid8, busy8, done8;
  logic [7:0] dout8, chain8_q = '0, func8 = '0;

  scan_readback_ctrl #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .recirc(1'b0), .scan_so(so8),
    .scan_en(en8), .scan_ce(ce8), .scan_si(si8), .dout(dout8),
    .dout_valid(valid8), .dout_ready(ready8), .busy(busy8), .done(done8));

  assign so8 = chain8_q[0];
  always @(posedge clk)
    if (ce8) chain8_q <= en8 ? {si8, chain8_q[7:1]} : func8;

  int n_cmp = 0, n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   exp8_q[$];
  int run_words, run_dones, run_shifts, run_capt, run_en;
  int words8, dones8;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops and compares on every transfer, tracks per-run events.
  initial begin
    logic         hold_chk = 1'b0;
    logic [W-1:0] hold_val = '0;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_chk = 1'b0;
      end else begin
        if (start && !busy) begin
          run_words = 0; run_dones = 0; run_shifts = 0; run_capt = 0; run_en = 0;
        end
        if (start8 && !busy8) begin
          words8 = 0; dones8 = 0;
        end
        if (hold_chk) begin
          chk("hold_valid", 32'(dout_valid), 32'd1);
          chk("hold_data", 32'(dout), 32'(hold_val));
        end
        hold_chk = dout_valid && !dout_ready;
        hold_val = dout;
        if (dout_valid && dout_ready) begin
          chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("word_data", 32'(dout), 32'(e));
          end
          run_words++;
        end
        if (scan_ce && scan_en) run_shifts++;
        if (scan_en) run_en++;
        if (busy && scan_ce && !scan_en) run_capt++;
        if (done) begin
          run_dones++;
          chk("done_last_word", 32'(exp_q.size()), 32'd0);
          chk("chain_at_done", 32'(chain_q), 32'(exp_chain));
        end
        if (valid8 && ready8) begin
          chk("word8_expected", 32'(exp8_q.size() != 0), 32'd1);
          if (exp8_q.size() != 0) chk("word8_data", 32'(dout8), 32'(exp8_q.pop_front()));
          words8++;
        end
        if (done8) begin
          dones8++;
          chk("done8_with_transfer", 32'(valid8 && ready8), 32'd1);
          chk("chain8_cleared", 32'(chain8_q), 32'd0);
        end
      end
    end
  end

  // mode 0: ready always 1; mode 1: ready low until stall, then released;
  // mode 2: random ready. stray holds start high while busy.
  task automatic run(input logic [L-1:0] v, input logic rc, input int mode,
                     input bit stray, input int abort_after);
    logic [L-1:0] t;
    int cyc = 0, hold = 0;
    bit stalled = 0;
    func_v = v;
    recirc = rc;
    exp_chain = rc ? v : '0;
    for (int j = 0; j < int'(NW); j++) begin
      t = v >> (j * W);
      exp_q.push_back(t[W-1:0]);
    end
    @(posedge clk); #1;
    start = 1'b1;
    dout_ready = (mode == 1) ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    start = stray;
    recirc = ~rc;
    while (busy && cyc < 500) begin
      if (mode == 2) dout_ready = 1'($urandom_range(0, 1));
      if (mode == 1) begin
        if (!stalled && scan_en && !scan_ce) begin
          stalled = 1;
          chk("stall_after_shifts", 32'(run_shifts), 32'd8);
          chk("stall_dout", 32'(dout), 32'(v[W-1:0]));
          chk("stall_valid", 32'(dout_valid), 32'd1);
        end else if (stalled) begin
          hold++;
          if (hold > 5) dout_ready = 1'b1;
        end
      end
      if (abort_after != 0 && run_shifts >= abort_after) begin
        rst = 1'b0;
        #1;
        chk("rst_scan_en", 32'(scan_en), 32'd0);
        chk("rst_scan_ce", 32'(scan_ce), 32'd0);
        chk("rst_scan_si", 32'(scan_si), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("abort_no_done", 32'(run_dones), 32'd0);
        exp_q.delete();
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("run_finished", 32'(busy), 32'd0);
    chk("run_words", 32'(run_words), 32'(NW));
    chk("run_dones", 32'(run_dones), 32'd1);
    chk("run_capture_cycles", 32'(run_capt), 32'd1);
    chk("run_shifts", 32'(run_shifts), 32'(L));
    chk("run_queue_empty", 32'(exp_q.size()), 32'd0);
    if (mode == 0) chk("shift_cycles_no_stall", 32'(run_en), 32'(L));
    @(posedge clk); #1;
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("idle_ce", 32'(scan_ce), 32'd1);
    exp_q.delete();
  endtask

  task automatic run8(input logic [7:0] v);
    int cyc = 0;
    func8 = v;
    exp8_q.push_back(v);
    @(posedge clk); #1 start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    while (busy8 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("run8_finished", 32'(busy8), 32'd0);
    chk("run8_words", 32'(words8), 32'd1);
    chk("run8_dones", 32'(dones8), 32'd1);
    exp8_q.delete();
  endtask

  initial begin
    #2;
    chk("reset_scan_en", 32'(scan_en), 32'd0);
    chk("reset_scan_ce", 32'(scan_ce), 32'd0);
    chk("reset_scan_si", 32'(scan_si), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_dout_valid", 32'(dout_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset8_ce", 32'(ce8), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_ce_high", 32'(scan_ce), 32'd1);
    chk("idle_en_low", 32'(scan_en), 32'd0);

    run(17'h12F4D, 1'b0, 0, 1'b0, 0);                  // D,4,F,2,1
    run(17'h12F4D, 1'b0, 1, 1'b0, 0);                  // back-pressure
    run(17'h1A5C3, 1'b1, 0, 1'b0, 0);                  // recirc restores chain
    run(17'($urandom()), 1'($urandom_range(0, 1)), 0, 1'b1, 0); // stray start
    run(17'($urandom()), 1'b0, 0, 1'b0, 9);            // reset after 9th shift
    run(17'($urandom()), 1'b0, 0, 1'b0, 0);
    for (int k = 0; k < 6; k++)
      run(17'($urandom()), 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), 0);

    run8(8'hA5);
    run8(8'($urandom()));
    run8(8'($urandom()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scan_readback_ctrl.md
Name: scan_readback_ctrl

Overview:
- Reader side of the scan-flop register netlists (dff cells with CE, NbarT, Si).
- On request, the block captures the chain contents with one functional clock, then shifts the chain out serially.
- Captured bits are packed into WORD_W-bit words and delivered on a valid/ready stream.
- Sits beside a synthesized register/counter netlist and drives that netlist's shared CE, NbarT and chain-head Si.

Parameters:
CHAIN_LEN, 17, number of flops in the scan chain (≥1)
WORD_W, 4, output word width (1..CHAIN_LEN)
CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter; derived, not overridable

Ports:
clk  in  1  system clock; drives the chain flops and this block
rst  in  1  reset, active-low, asynchronous
start  in  1  readback request; sampled only in IDLE
recirc  in  1  1: scan_si = scan_so (non-destructive read); 0: scan_si = 0 (chain cleared); sampled with start
scan_so  in  1  serial output of the last flop in the chain
scan_en  out  1  drives NbarT of every chain flop; 1 = shift
scan_ce  out  1  drives CE of every chain flop
scan_si  out  1  drives Si of the first chain flop
dout  out  WORD_W  packed readback word
dout_valid  out  1  dout holds a word
dout_ready  in  1  consumer accepts dout when high with dout_valid
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the final word is accepted

Behaviour:
- Reset (async assert, sync release): state IDLE, and every output is 0 — scan_en, scan_ce, scan_si, dout, dout_valid, busy, done. The bit counter, accumulator and latched recirc are also cleared.
- While in IDLE, scan_ce=1 and scan_en=0, so the netlist runs functionally.
- IDLE: start=1 latches recirc, clears the accumulator and counter, and moves to CAPTURE.
- CAPTURE (1 cycle): scan_en=0, scan_ce=1 (functional capture edge). Next state is SHIFT.
- SHIFT: scan_en=1; scan_si per the latched recirc.
  - scan_ce=1 unless stalled. Stall condition: the accumulator holds WORD_W bits and dout_valid=1 with dout_ready=0.
  - Each clk edge with scan_ce=1 samples scan_so into accumulator bit [n mod WORD_W]; n counts bits taken, starting at 0. The bit from the last flop therefore lands in bit 0 of word 0.
  - When WORD_W bits are collected, or n reaches CHAIN_LEN, the accumulator transfers to dout on the next edge where the holding register is free. dout_valid rises in that cycle.
  - A final partial word is zero-padded in its upper bits.
  - After CHAIN_LEN shifts: scan_ce=0, scan_en=0, next state DRAIN.
- Word count is ceil(CHAIN_LEN/WORD_W). Defaults give 5 words; word 4 carries 1 bit.
- Handshake:
  - A transfer happens on an edge where dout_valid and dout_ready are both 1.
  - dout and dout_valid stay stable while dout_valid=1 and dout_ready=0.
  - A transfer and a refill in the same cycle are allowed, giving back-to-back valid words.
- DRAIN: waits for the last word to transfer. In that same edge, done=1 for one cycle, then IDLE.
- Simultaneous events:
  - start while busy is ignored.
  - start in the same cycle as the DRAIN→IDLE transition is ignored; it is honoured from IDLE on the next cycle.
- With recirc=1, CHAIN_LEN shifts restore the chain to its captured state exactly.
- Reset mid-operation: immediate return to IDLE and all outputs 0. Partial data is discarded and no done pulse is issued.
- Throughput: with dout_ready held at 1, SHIFT takes exactly CHAIN_LEN cycles with no stall.

Decomposition:
- Package scan_rb_pkg:
  - state enum {IDLE, CAPTURE, SHIFT, DRAIN}
  - a function for the ceil word count
- Sub-module: scan_word_packer. It holds the accumulator, index and holding register, and runs the valid/ready logic plus the stall output.
- The top level keeps the FSM, the bit counter and the scan_si mux.

Test Plan:
1. Defaults, dout_ready=1, recirc=0, scan_so driven bits 1,0,1,1, 0,0,1,0, 1,1,1,1, 0,1,0,0, 1 in shift order → dout sequence 4'hD, 4'h4, 4'hF, 4'h2, 4'h1. CAPTURE lasts 1 cycle, SHIFT 17 cycles; done pulses once and busy returns to 0.
2. Back-pressure: dout_ready=0 throughout SHIFT → scan_ce drops after bit 8. dout stays 4'hD, with dout_valid high. Releasing dout_ready resumes the shift with no lost or duplicated bits; output is identical to test 1.
3. recirc=1 against a 17-flop chain model preloaded with 17'h1A5C3 → words 3,C,5,A,1, and the chain still holds 17'h1A5C3 at done.
4. start pulsed again in SHIFT and in DRAIN → ignored: exactly 5 words and a single done pulse.
5. rst asserted low after the 9th shift → all outputs 0 asynchronously, with no done pulse. A new start then yields a full, correct 5-word readback.
6. CHAIN_LEN=8, WORD_W=8 → one word equal to the 8 shifted bits LSB-first, e.g. 8'hA5; done follows the single transfer.
